ahb_master_arbiter: RTL and testbench

Two-master, one-slave AHB-Lite arbiter that shares a single slave port between the core's instruction-fetch master (I) and load/store master (D). It sits between `riscv32ia` and one `ahb_cache` instance, replacing the separate I and D cache paths with one unified memory. Arbitration is round-robin with bus-lock support. Any address phase that loses arbitration is captured in a per-master pending register, so masters need no grant signal.

---
 rtl/ahb_master_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_arbiter.sv
// Two-master (instruction/data) to one-slave AHB-Lite arbiter. Round-robin with
// bus lock; address phases that lose arbitration are parked per master, so no grant signal is needed.
module ahb_master_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,

  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic                  i_hwrite,
  input  logic [1:0]            i_htrans,
  input  logic [2:0]            i_hsize,
  input  logic [2:0]            i_hburst,
  input  logic [3:0]            i_hprot,
  input  logic                  i_hmastlock,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  output logic [DATA_WIDTH-1:0] i_hrdata,
  output logic                  i_hready,
  output logic                  i_hresp,

  input  logic [ADDR_WIDTH-1:0] d_haddr,
  input  logic                  d_hwrite,
  input  logic [1:0]            d_htrans,
  input  logic [2:0]            d_hsize,
  input  logic [2:0]            d_hburst,
  input  logic [3:0]            d_hprot,
  input  logic                  d_hmastlock,
  input  logic [DATA_WIDTH-1:0] d_hwdata,
  output logic [DATA_WIDTH-1:0] d_hrdata,
  output logic                  d_hready,
  output logic                  d_hresp,

  output logic [ADDR_WIDTH-1:0] s_haddr,
  output logic                  s_hwrite,
  output logic [1:0]            s_htrans,
  output logic [2:0]            s_hsize,
  output logic [2:0]            s_hburst,
  output logic [3:0]            s_hprot,
  output logic                  s_hmastlock,
  output logic [DATA_WIDTH-1:0] s_hwdata,
  input  logic [DATA_WIDTH-1:0] s_hrdata,
  input  logic                  s_hready,
  input  logic                  s_hresp
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] haddr;
    logic                  hwrite;
    logic [1:0]            htrans;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic                  hmastlock;
  } aphase_t;

  aphase_t i_live, d_live, src_i, src_d, win, s_out;
  aphase_t pend_i_fld_q, pend_i_fld_d, pend_d_fld_q, pend_d_fld_d;
  aphase_t hold_q, hold_d;

  logic   pend_i_q, pend_i_d, pend_d_q, pend_d_d;
  owner_e downer_q, downer_d;
  logic   last_q, last_d;          // 1: D won the last grant
  logic   lock_vld_q, lock_vld_d;
  logic   lock_who_q, lock_who_d;  // 1: D holds the lock

  logic req_i, req_d, pv_i, pv_d, elig_i, elig_d;
  logic any_cand, sel_d, grant;

  always_comb begin
    i_live = '{haddr: i_haddr, hwrite: i_hwrite, htrans: i_htrans, hsize: i_hsize,
               hburst: i_hburst, hprot: i_hprot, hmastlock: i_hmastlock};
    d_live = '{haddr: d_haddr, hwrite: d_hwrite, htrans: d_htrans, hsize: d_hsize,
               hburst: d_hburst, hprot: d_hprot, hmastlock: d_hmastlock};
  end

  // Master-side handshake: the data-phase owner follows the slave, a parked master is stalled
  always_comb begin
    i_hready = 1'b1;
    d_hready = 1'b1;
    if (downer_q == OWN_I) i_hready = s_hready;
    else if (pend_i_q)     i_hready = 1'b0;
    if (downer_q == OWN_D) d_hready = s_hready;
    else if (pend_d_q)     d_hready = 1'b0;
    i_hresp  = (downer_q == OWN_I) && s_hresp;
    d_hresp  = (downer_q == OWN_D) && s_hresp;
    i_hrdata = s_hrdata;
    d_hrdata = s_hrdata;
  end

  // Arbitration; a parked entry is dropped in the closing cycle of an ERROR to its master
  always_comb begin
    req_i    = i_htrans[1] && i_hready;
    req_d    = d_htrans[1] && d_hready;
    pv_i     = pend_i_q && !((downer_q == OWN_I) && s_hresp && s_hready);
    pv_d     = pend_d_q && !((downer_q == OWN_D) && s_hresp && s_hready);
    elig_i   = (pv_i || req_i) && !(lock_vld_q && lock_who_q);
    elig_d   = (pv_d || req_d) && !(lock_vld_q && !lock_who_q);
    any_cand = elig_i || elig_d;
    sel_d    = elig_d && (!elig_i || !last_q);
    grant    = any_cand && s_hready;
    src_i    = pv_i ? pend_i_fld_q : i_live;
    src_d    = pv_d ? pend_d_fld_q : d_live;
    win      = sel_d ? src_d : src_i;
  end

  // Slave port: winner's address phase, else the last granted fields stored as IDLE
  always_comb begin
    s_out       = any_cand ? win : hold_q;
    s_haddr     = s_out.haddr;
    s_hwrite    = s_out.hwrite;
    s_htrans    = s_out.htrans;
    s_hsize     = s_out.hsize;
    s_hburst    = s_out.hburst;
    s_hprot     = s_out.hprot;
    s_hmastlock = s_out.hmastlock;
    case (downer_q)
      OWN_I:   s_hwdata = i_hwdata;
      OWN_D:   s_hwdata = d_hwdata;
      default: s_hwdata = '0;
    endcase
  end

  always_comb begin
    pend_i_d     = pv_i;
    pend_d_d     = pv_d;
    pend_i_fld_d = pend_i_fld_q;
    pend_d_fld_d = pend_d_fld_q;
    downer_d     = downer_q;
    last_d       = last_q;
    lock_vld_d   = lock_vld_q;
    lock_who_d   = lock_who_q;
    hold_d       = hold_q;
    if (grant) begin
      downer_d       = sel_d ? OWN_D : OWN_I;
      last_d         = sel_d;
      lock_vld_d     = win.hmastlock;
      lock_who_d     = sel_d;
      hold_d         = win;
      hold_d.htrans  = HTRANS_IDLE;
      if (sel_d) pend_d_d = 1'b0;
      else       pend_i_d = 1'b0;
    end else if (s_hready) begin
      downer_d = OWN_NONE;
      // Holder skipped this slot: the lock survives only while it keeps hmastlock high
      if (lock_vld_q) lock_vld_d = lock_who_q ? d_hmastlock : i_hmastlock;
    end
    if (req_i && !(grant && !sel_d)) begin
      pend_i_d     = 1'b1;
      pend_i_fld_d = i_live;
    end
    if (req_d && !(grant && sel_d)) begin
      pend_d_d     = 1'b1;
      pend_d_fld_d = d_live;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_i_q     <= 1'b0;
      pend_d_q     <= 1'b0;
      pend_i_fld_q <= '0;
      pend_d_fld_q <= '0;
      downer_q     <= OWN_NONE;
      last_q       <= 1'b0;
      lock_vld_q   <= 1'b0;
      lock_who_q   <= 1'b0;
      hold_q       <= '0;
    end else begin
      pend_i_q     <= pend_i_d;
      pend_d_q     <= pend_d_d;
      pend_i_fld_q <= pend_i_fld_d;
      pend_d_fld_q <= pend_d_fld_d;
      downer_q     <= downer_d;
      last_q       <= last_d;
      lock_vld_q   <= lock_vld_d;
      lock_who_q   <= lock_who_d;
      hold_q       <= hold_d;
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Scoreboard bench for ahb_master_arbiter: directed I/D traffic, expected slave-side
// grants (address, cycle, data phase) queued by the stimulus and popped by a monitor.
module tb_ahb_master_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [AW-1:0] i_haddr, d_haddr, s_haddr;
  logic          i_hwrite, d_hwrite, s_hwrite;
  logic [1:0]    i_htrans, d_htrans, s_htrans;
  logic [2:0]    i_hsize, d_hsize, s_hsize;
  logic [2:0]    i_hburst, d_hburst, s_hburst;
  logic [3:0]    i_hprot, d_hprot, s_hprot;
  logic          i_hmastlock, d_hmastlock, s_hmastlock;
  logic [DW-1:0] i_hwdata, d_hwdata, s_hwdata;
  logic [DW-1:0] i_hrdata, d_hrdata, s_hrdata;
  logic          i_hready, d_hready, s_hready;
  logic          i_hresp, d_hresp, s_hresp;

  ahb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .i_haddr(i_haddr), .i_hwrite(i_hwrite), .i_htrans(i_htrans), .i_hsize(i_hsize),
    .i_hburst(i_hburst), .i_hprot(i_hprot), .i_hmastlock(i_hmastlock), .i_hwdata(i_hwdata),
    .i_hrdata(i_hrdata), .i_hready(i_hready), .i_hresp(i_hresp),
    .d_haddr(d_haddr), .d_hwrite(d_hwrite), .d_htrans(d_htrans), .d_hsize(d_hsize),
    .d_hburst(d_hburst), .d_hprot(d_hprot), .d_hmastlock(d_hmastlock), .d_hwdata(d_hwdata),
    .d_hrdata(d_hrdata), .d_hready(d_hready), .d_hresp(d_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_htrans(s_htrans), .s_hsize(s_hsize),
    .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // Slave read data is a fixed function of the data-phase address
  function automatic logic [31:0] rfun(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  logic [31:0] sdp_addr;
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) sdp_addr <= '0;
    else if (s_hready && s_htrans[1]) sdp_addr <= s_haddr;
  end
  assign s_hrdata = rfun(sdp_addr);

  typedef struct {
    bit          mid;     // 1: D, 0: I
    logic [31:0] addr;
    bit          write;
    bit          lock;
    logic [31:0] wdata;
    bit          resp;
    int          ecyc;
  } exp_t;

  exp_t expq[$];
  exp_t mon_dp;
  bit   mon_v = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: data-phase completion of the previous grant, then any new grant
  initial begin
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        mon_v = 1'b0;
      end else begin
        if (mon_v && s_hready) begin
          if (mon_dp.mid) begin
            chk1("d_hready_dphase", d_hready, 1'b1);
            chk1("d_hresp_dphase", d_hresp, mon_dp.resp);
            if (!mon_dp.write && !mon_dp.resp) chk32("d_hrdata", d_hrdata, rfun(mon_dp.addr));
          end else begin
            chk1("i_hready_dphase", i_hready, 1'b1);
            chk1("i_hresp_dphase", i_hresp, mon_dp.resp);
            if (!mon_dp.write && !mon_dp.resp) chk32("i_hrdata", i_hrdata, rfun(mon_dp.addr));
          end
          if (mon_dp.write) chk32("s_hwdata", s_hwdata, mon_dp.wdata);
          mon_v = 1'b0;
        end
        if (s_htrans[1] && s_hready) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got addr 0x%08h want no grant (cycle %0d)", s_haddr, cyc);
          end else begin
            mon_dp = expq.pop_front();
            chk32("s_haddr", s_haddr, mon_dp.addr);
            chk1("s_hwrite", s_hwrite, mon_dp.write);
            chk1("s_hmastlock", s_hmastlock, mon_dp.lock);
            chk32("grant_cycle", 32'(cyc), 32'(mon_dp.ecyc));
            mon_v = 1'b1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic req(input bit mid, input logic [31:0] a, input bit w, input bit lk);
    if (mid) begin
      d_htrans = 2'b10; d_haddr = a; d_hwrite = w; d_hmastlock = lk;
    end else begin
      i_htrans = 2'b10; i_haddr = a; i_hwrite = w; i_hmastlock = lk;
    end
  endtask

  task automatic idle(input bit mid);
    if (mid) begin d_htrans = 2'b00; d_hmastlock = 1'b0; end
    else     begin i_htrans = 2'b00; i_hmastlock = 1'b0; end
  endtask

  task automatic expect_grant(input bit mid, input logic [31:0] a, input bit w, input bit lk,
                              input logic [31:0] wd, input bit rsp, input int ec);
    exp_t e;
    e = '{mid, a, w, lk, wd, rsp, ec};
    expq.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [31:0] ia, da;
    bit acc_i, acc_d;

    HRESETn = 1'b0;
    s_hready = 1'b1; s_hresp = 1'b0;
    i_haddr = '0; i_hwrite = 1'b0; i_htrans = 2'b00; i_hsize = 3'b010; i_hburst = 3'b000;
    i_hprot = 4'b0011; i_hmastlock = 1'b0; i_hwdata = '0;
    d_haddr = '0; d_hwrite = 1'b0; d_htrans = 2'b00; d_hsize = 3'b010; d_hburst = 3'b000;
    d_hprot = 4'b0011; d_hmastlock = 1'b0; d_hwdata = '0;

    // Reset state
    #12;
    chk1("rst_i_hready", i_hready, 1'b1);
    chk1("rst_d_hready", d_hready, 1'b1);
    chk32("rst_s_htrans", 32'(s_htrans), 32'd0);
    chk32("rst_s_haddr", s_haddr, 32'd0);
    chk1("rst_i_hresp", i_hresp, 1'b0);
    chk1("rst_d_hresp", d_hresp, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Isolated fetch: address reaches the slave in the same cycle
    step(); c = cyc;
    req(1'b0, 32'h100, 1'b0, 1'b0);
    expect_grant(1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, c);
    step(); idle(1'b0);
    step(); step();

    // Collision: D wins the first tie, I is parked and issued one cycle later
    d_hwdata = 32'hDEAD_BEEF;
    step(); c = cyc;
    req(1'b0, 32'h10, 1'b0, 1'b0);
    req(1'b1, 32'h2000, 1'b1, 1'b0);
    expect_grant(1'b1, 32'h2000, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, c);
    expect_grant(1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, c + 1);
    step(); idle(1'b0); idle(1'b1);
    @(negedge HCLK);
    chk1("coll_i_hready_parked", i_hready, 1'b0);
    step();
    @(negedge HCLK);
    chk1("coll_i_hready_own", i_hready, 1'b1);
    step(); step();

    // Round-robin: both masters request every cycle for 8 cycles
    step(); c = cyc;
    ia = 32'h400; da = 32'h3000;
    expect_grant(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, c);
    expect_grant(1'b0, 32'h400,  1'b0, 1'b0, 32'h0, 1'b0, c + 1);
    expect_grant(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0, 1'b0, c + 2);
    expect_grant(1'b0, 32'h404,  1'b0, 1'b0, 32'h0, 1'b0, c + 3);
    expect_grant(1'b1, 32'h3008, 1'b0, 1'b0, 32'h0, 1'b0, c + 4);
    expect_grant(1'b0, 32'h408,  1'b0, 1'b0, 32'h0, 1'b0, c + 5);
    expect_grant(1'b1, 32'h300C, 1'b0, 1'b0, 32'h0, 1'b0, c + 6);
    expect_grant(1'b0, 32'h40C,  1'b0, 1'b0, 32'h0, 1'b0, c + 7);
    expect_grant(1'b1, 32'h3010, 1'b0, 1'b0, 32'h0, 1'b0, c + 8);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      req(1'b0, ia, 1'b0, 1'b0);
      req(1'b1, da, 1'b0, 1'b0);
      @(negedge HCLK);
      acc_i = i_hready;
      acc_d = d_hready;
      if (acc_i) ia = ia + 32'd4;
      if (acc_d) da = da + 32'd4;
    end
    step(); idle(1'b0); idle(1'b1);
    step(); step();

    // Locked D sequence: I parked through the slot after the last locked transfer
    d_hwdata = 32'h1234_5678;
    step(); c = cyc;
    req(1'b1, 32'h5000, 1'b1, 1'b1);
    expect_grant(1'b1, 32'h5000, 1'b1, 1'b1, 32'h1234_5678, 1'b0, c);
    expect_grant(1'b1, 32'h5004, 1'b1, 1'b1, 32'h1234_5678, 1'b0, c + 1);
    expect_grant(1'b1, 32'h5008, 1'b1, 1'b1, 32'h1234_5678, 1'b0, c + 2);
    expect_grant(1'b0, 32'h600,  1'b0, 1'b0, 32'h0, 1'b0, c + 4);
    step();
    req(1'b1, 32'h5004, 1'b1, 1'b1);
    req(1'b0, 32'h600, 1'b0, 1'b0);
    step();
    req(1'b1, 32'h5008, 1'b1, 1'b1);
    idle(1'b0);
    @(negedge HCLK);
    chk1("lock_i_hready_held", i_hready, 1'b0);
    step();
    idle(1'b1);
    @(negedge HCLK);
    chk32("lock_gap_htrans", 32'(s_htrans), 32'd0);
    chk1("lock_gap_i_hready", i_hready, 1'b0);
    step(); step(); step();

    // Two wait states then ERROR on a D read while I is parked
    step(); c = cyc;
    req(1'b0, 32'h800, 1'b0, 1'b0);
    req(1'b1, 32'h7000, 1'b0, 1'b0);
    expect_grant(1'b1, 32'h7000, 1'b0, 1'b0, 32'h0, 1'b1, c);
    expect_grant(1'b0, 32'h800,  1'b0, 1'b0, 32'h0, 1'b0, c + 4);
    step(); idle(1'b0); idle(1'b1); s_hready = 1'b0;
    @(negedge HCLK);
    chk1("wait1_d_hready", d_hready, 1'b0);
    chk1("wait1_i_hready", i_hready, 1'b0);
    step();
    @(negedge HCLK);
    chk1("wait2_d_hready", d_hready, 1'b0);
    step(); s_hresp = 1'b1;
    @(negedge HCLK);
    chk1("err1_d_hresp", d_hresp, 1'b1);
    chk1("err1_i_hresp", i_hresp, 1'b0);
    chk1("err1_i_hready", i_hready, 1'b0);
    step(); s_hready = 1'b1;
    @(negedge HCLK);
    chk1("err2_d_hresp", d_hresp, 1'b1);
    chk1("err2_i_hresp", i_hresp, 1'b0);
    chk1("err2_i_hready", i_hready, 1'b0);
    step(); s_hresp = 1'b0;
    @(negedge HCLK);
    chk1("err_after_i_hready", i_hready, 1'b1);
    step(); step();

    // Reset mid-transfer: parked I and D's data phase are dropped
    step(); c = cyc;
    req(1'b0, 32'h900, 1'b0, 1'b0);
    req(1'b1, 32'hA000, 1'b0, 1'b0);
    expect_grant(1'b1, 32'hA000, 1'b0, 1'b0, 32'h0, 1'b0, c);
    step(); idle(1'b0); idle(1'b1);
    HRESETn = 1'b0;
    #1;
    chk1("midrst_i_hready", i_hready, 1'b1);
    chk32("midrst_s_htrans", 32'(s_htrans), 32'd0);
    chk32("midrst_s_haddr", s_haddr, 32'd0);
    step();
    @(negedge HCLK);
    #1 HRESETn = 1'b1;
    step(); step(); step();

    for (int k = 0; k < 20 && expq.size() != 0; k++) step();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expected grants never seen, want 0", expq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
